// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: the initiator side of a 1-cycle-latency IMem read port.
// Owns the fetch PC, pairs each returned instruction with the PC that fetched it,
// and handles decode stall, execute redirect and bad-PC faults. A fault is sticky
// until reset.
module instruction_fetch_unit #(
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned INST_WIDTH       = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned IMEM_DEPTH_WORDS = 32768,
   parameter int unsigned PC_STEP          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirectValid,
   input  logic [ADDR_WIDTH-1:0] redirectPc,
   input  logic [INST_WIDTH-1:0] imemInstruction,
   output logic [ADDR_WIDTH-1:0] imemPc,
   output logic                  imemStall,
   output logic                  fetchValid,
   output logic [ADDR_WIDTH-1:0] fetchPc,
   output logic [INST_WIDTH-1:0] fetchInstruction,
   output logic                  fault,
   output logic [ADDR_WIDTH-1:0] faultPc,
   output logic [31:0]           fetchCount
);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FAULT = 1'b1
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_WORD = ADDR_WIDTH'(IMEM_DEPTH_WORDS);

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] inflight_pc_q;
   logic                  inflight_valid_q;
   logic [ADDR_WIDTH-1:0] fault_pc_q;
   logic [31:0]           fetch_count_q;
   logic [31:0]           fetch_count_d;

   logic [ADDR_WIDTH-1:0] pc_word_idx;
   logic [ADDR_WIDTH-1:0] redirect_word_idx;
   logic                  pc_out_of_range;
   logic                  redirect_bad;
   logic                  accept;

   // Word indices are compared unsigned; the upper two bits are zero-filled by the shift.
   assign pc_word_idx       = pc_q >> 2;
   assign redirect_word_idx = redirectPc >> 2;
   assign pc_out_of_range   = (pc_word_idx >= DEPTH_WORD);
   assign redirect_bad      = (redirectPc[1:0] != 2'b00) || (redirect_word_idx >= DEPTH_WORD);

   // A redirect squashes whatever is on the fetch port in the same cycle it arrives.
   assign fetchValid       = inflight_valid_q && (state_q == S_RUN) && !redirectValid;
   assign fetchPc          = inflight_pc_q;
   assign fetchInstruction = imemInstruction;
   assign imemPc           = pc_q;
   assign imemStall        = (stall && !redirectValid) || (state_q == S_FAULT);
   assign fault            = (state_q == S_FAULT);
   assign faultPc          = fault_pc_q;
   assign fetchCount       = fetch_count_q;

   assign accept        = fetchValid && !stall;
   assign fetch_count_d = fetch_count_q + 32'd1;

   // Fetch FSM and PC pipeline: redirect > stall > out-of-range > sequential advance.
   // NOTE: every register here uses <= so all of them see the pre-edge values of
   // one another; a blocking = would let pc_q update before inflight_pc_q samples it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_RUN;
         pc_q             <= RESET_VECTOR;
         inflight_pc_q    <= '0;
         inflight_valid_q <= 1'b0;
         fault_pc_q       <= '0;
         fetch_count_q    <= '0;
      end else begin
         if (accept) begin
            fetch_count_q <= fetch_count_d;
         end
         unique case (state_q)
            S_RUN: begin
               if (redirectValid) begin
                  inflight_valid_q <= 1'b0;
                  if (redirect_bad) begin
                     state_q    <= S_FAULT;
                     fault_pc_q <= redirectPc;
                  end else begin
                     pc_q <= redirectPc;
                  end
               end else if (!stall) begin
                  if (pc_out_of_range) begin
                     state_q          <= S_FAULT;
                     fault_pc_q       <= pc_q;
                     inflight_valid_q <= 1'b0;
                  end else begin
                     inflight_pc_q    <= pc_q;
                     inflight_valid_q <= 1'b1;
                     pc_q             <= pc_q + STEP;
                  end
               end
            end
            S_FAULT: begin
               // Frozen until reset; redirects are ignored.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by a
// randomized run against a cycle-level reference model. IMem is modelled here as a
// registered-output ROM whose contents are a hash of the address.
module tb_instruction_fetch_unit;

   localparam int unsigned DEPTH = 32768;
   localparam logic [31:0] TOP   = DEPTH * 4;

   logic        clk = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // Main instance (default depth)
   logic        rst, stall, redirect_valid;
   logic [31:0] redirect_pc, imem_inst, imem_pc, fetch_pc, fetch_inst, fault_pc, fetch_count;
   logic        imem_stall, fetch_valid, fault;

   // Small instance (depth 4 words)
   logic        rst4, stall4, redirect_valid4;
   logic [31:0] redirect_pc4, imem_inst4, imem_pc4, fetch_pc4, fetch_inst4, fault_pc4, fetch_count4;
   logic        imem_stall4, fetch_valid4, fault4;

   always #5 clk = ~clk;

   instruction_fetch_unit u_dut (
      .clk(clk), .rst(rst), .stall(stall), .redirectValid(redirect_valid),
      .redirectPc(redirect_pc), .imemInstruction(imem_inst), .imemPc(imem_pc),
      .imemStall(imem_stall), .fetchValid(fetch_valid), .fetchPc(fetch_pc),
      .fetchInstruction(fetch_inst), .fault(fault), .faultPc(fault_pc),
      .fetchCount(fetch_count)
   );

   instruction_fetch_unit #(.IMEM_DEPTH_WORDS(4)) u_dut4 (
      .clk(clk), .rst(rst4), .stall(stall4), .redirectValid(redirect_valid4),
      .redirectPc(redirect_pc4), .imemInstruction(imem_inst4), .imemPc(imem_pc4),
      .imemStall(imem_stall4), .fetchValid(fetch_valid4), .fetchPc(fetch_pc4),
      .fetchInstruction(fetch_inst4), .fault(fault4), .faultPc(fault_pc4),
      .fetchCount(fetch_count4)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // IMem: 1-cycle latency, output register held while imemStall is high.
   always @(posedge clk) begin
      if (!imem_stall)  imem_inst  <= inst_of(imem_pc);
      if (!imem_stall4) imem_inst4 <= inst_of(imem_pc4);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      checks++; if (imem_pc !== 32'h0) begin errors++; $display("FAIL reset_imem_pc got=%h exp=0", imem_pc); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'(4 * k))
            begin errors++; $display("FAIL seq_pc%0d got=%b/%h exp=1/%h", k, fetch_valid, fetch_pc, 4 * k); end
         checks++; if (fetch_inst !== inst_of(32'(4 * k)))
            begin errors++; $display("FAIL seq_inst%0d got=%h exp=%h", k, fetch_inst, inst_of(32'(4 * k))); end
         checks++; if (imem_pc !== 32'(4 * k + 4))
            begin errors++; $display("FAIL seq_imem_pc%0d got=%h exp=%h", k, imem_pc, 4 * k + 4); end
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         checks++; if (imem_stall !== 1'b1) begin errors++; $display("FAIL stall_imem_stall%0d got=%b exp=1", k, imem_stall); end
         checks++; if (fetch_pc !== 32'h8 || fetch_inst !== inst_of(32'h8) || imem_pc !== 32'hC)
            begin errors++; $display("FAIL stall_frozen%0d got=%h/%h/%h exp=8/%h/c", k, fetch_pc, fetch_inst, imem_pc, inst_of(32'h8)); end
         checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count%0d got=%0d exp=2", k, fetch_count); end
         @(posedge clk); #1;
      end
      stall = 1'b0;
      settle();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h8)
         begin errors++; $display("FAIL stall_release got=%b/%h exp=1/8", fetch_valid, fetch_pc); end
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hC || fetch_count !== 32'd3)
         begin errors++; $display("FAIL stall_after got=%b/%h/%0d exp=1/c/3", fetch_valid, fetch_pc, fetch_count); end
   endtask

   task automatic test_redirect();
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h10)
         begin errors++; $display("FAIL redir_pre got=%b/%h exp=1/10", fetch_valid, fetch_pc); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      settle();
      checks++; if (fetch_valid !== 1'b0 || imem_stall !== 1'b0)
         begin errors++; $display("FAIL redir_squash got=%b/%b exp=0/0", fetch_valid, imem_stall); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      settle();
      checks++; if (imem_pc !== 32'h100 || fetch_valid !== 1'b0)
         begin errors++; $display("FAIL redir_bubble got=%h/%b exp=100/0", imem_pc, fetch_valid); end
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h100 || fetch_inst !== inst_of(32'h100))
         begin errors++; $display("FAIL redir_target got=%b/%h/%h exp=1/100/%h", fetch_valid, fetch_pc, fetch_inst, inst_of(32'h100)); end
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h104)
         begin errors++; $display("FAIL redir_next got=%b/%h exp=1/104", fetch_valid, fetch_pc); end
   endtask

   task automatic test_redirect_with_stall();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      settle();
      checks++; if (imem_stall !== 1'b0 || fetch_valid !== 1'b0)
         begin errors++; $display("FAIL rs_wins got=%b/%b exp=0/0", imem_stall, fetch_valid); end
      @(posedge clk); #1;
      stall = 1'b0; redirect_valid = 1'b0;
      settle();
      checks++; if (imem_pc !== 32'h40 || fetch_valid !== 1'b0)
         begin errors++; $display("FAIL rs_bubble got=%h/%b exp=40/0", imem_pc, fetch_valid); end
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h40)
         begin errors++; $display("FAIL rs_target got=%b/%h exp=1/40", fetch_valid, fetch_pc); end
   endtask

   task automatic test_fault_redirect();
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      settle();
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL flt_squash got=%b exp=0", fetch_valid); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      settle();
      checks++; if (fault !== 1'b1 || fault_pc !== 32'h102 || imem_stall !== 1'b1)
         begin errors++; $display("FAIL flt_set got=%b/%h/%b exp=1/102/1", fault, fault_pc, imem_stall); end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         checks++; if (fault !== 1'b1 || fetch_valid !== 1'b0 || imem_pc !== 32'h44)
            begin errors++; $display("FAIL flt_sticky%0d got=%b/%b/%h exp=1/0/44", k, fault, fetch_valid, imem_pc); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      checks++; if (fault !== 1'b0 || imem_pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_count !== 32'd0)
         begin errors++; $display("FAIL flt_reset got=%b/%h/%b/%0d exp=0/0/0/0", fault, imem_pc, fetch_valid, fetch_count); end
   endtask

   task automatic test_reset_mid_stall();
      tick(); tick(); tick();
      stall = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      checks++; if (imem_pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_count !== 32'd0 || imem_stall !== 1'b1)
         begin errors++; $display("FAIL rstall_state got=%h/%b/%0d/%b exp=0/0/0/1", imem_pc, fetch_valid, fetch_count, imem_stall); end
      stall = 1'b0;
      tick();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || fetch_inst !== inst_of(32'h0))
         begin errors++; $display("FAIL rstall_restart got=%b/%h/%h exp=1/0/%h", fetch_valid, fetch_pc, fetch_inst, inst_of(32'h0)); end
   endtask

   task automatic test_depth_fault();
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (fetch_valid4 !== 1'b1 || fetch_pc4 !== 32'(4 * k) || fetch_inst4 !== inst_of(32'(4 * k)))
            begin errors++; $display("FAIL d4_pc%0d got=%b/%h exp=1/%h", k, fetch_valid4, fetch_pc4, 4 * k); end
      end
      tick();
      checks++; if (fault4 !== 1'b1 || fault_pc4 !== 32'h10 || fetch_count4 !== 32'd4 || fetch_valid4 !== 1'b0)
         begin errors++; $display("FAIL d4_fault got=%b/%h/%0d/%b exp=1/10/4/0", fault4, fault_pc4, fetch_count4, fetch_valid4); end
      tick(); tick();
      checks++; if (fault4 !== 1'b1 || imem_pc4 !== 32'h10 || fetch_count4 !== 32'd4)
         begin errors++; $display("FAIL d4_sticky got=%b/%h/%0d exp=1/10/4", fault4, imem_pc4, fetch_count4); end
      stall4 = 1'b1;
      rst4 = 1'b1;
      tick();
      rst4 = 1'b0;
      settle();
      checks++; if (fault4 !== 1'b0 || imem_pc4 !== 32'h0 || fetch_valid4 !== 1'b0)
         begin errors++; $display("FAIL d4_reset got=%b/%h/%b exp=0/0/0", fault4, imem_pc4, fetch_valid4); end
      stall4 = 1'b0;
   endtask

   // Reference model: PC presented to IMem, the PC whose instruction is on the fetch
   // port (if any), sticky fault and accepted-instruction count.
   task automatic test_random(input int n_cycles);
      logic [31:0] m_issue, m_show, m_fpc, m_count;
      logic        m_show_ok, m_fault, exp_fv, exp_ist;
      logic        r_rst, r_stall, r_rv;
      logic [31:0] r_pc;
      int          sel;
      m_issue = 32'h0; m_show = 32'h0; m_fpc = 32'h0; m_count = 32'h0;
      m_show_ok = 1'b0; m_fault = 1'b0;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      tick();
      for (int c = 0; c < n_cycles; c++) begin
         r_rst   = ($urandom_range(99) < (m_fault ? 15 : 1));
         r_stall = ($urandom_range(99) < 25);
         r_rv    = ($urandom_range(99) < 8);
         sel     = int'($urandom_range(9));
         if (sel < 6)      r_pc = {$urandom_range(255), 2'b00};
         else if (sel < 8) r_pc = TOP - 32'(4 * $urandom_range(1, 6));
         else if (sel < 9) r_pc = {$urandom_range(255), 2'b00} | 32'($urandom_range(1, 3));
         else              r_pc = TOP + 32'(4 * $urandom_range(0, 64));
         rst = r_rst; stall = r_stall; redirect_valid = r_rv; redirect_pc = r_pc;
         @(negedge clk);
         exp_fv  = m_show_ok && !m_fault && !r_rv;
         exp_ist = (r_stall && !r_rv) || m_fault;
         checks++; if (fetch_valid !== exp_fv || imem_pc !== m_issue || imem_stall !== exp_ist || fault !== m_fault)
            begin errors++; $display("FAIL rnd_ctl c%0d got=%b/%h/%b/%b exp=%b/%h/%b/%b", c, fetch_valid, imem_pc, imem_stall, fault, exp_fv, m_issue, exp_ist, m_fault); end
         checks++; if (fetch_count !== m_count)
            begin errors++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", c, fetch_count, m_count); end
         if (exp_fv) begin
            checks++; if (fetch_pc !== m_show || fetch_inst !== inst_of(m_show))
               begin errors++; $display("FAIL rnd_data c%0d got=%h/%h exp=%h/%h", c, fetch_pc, fetch_inst, m_show, inst_of(m_show)); end
         end
         if (m_fault) begin
            checks++; if (fault_pc !== m_fpc)
               begin errors++; $display("FAIL rnd_fault_pc c%0d got=%h exp=%h", c, fault_pc, m_fpc); end
         end
         // Advance the model across this clock edge.
         if (r_rst) begin
            m_issue = 32'h0; m_show_ok = 1'b0; m_fault = 1'b0; m_fpc = 32'h0; m_count = 32'h0;
         end else begin
            if (exp_fv && !r_stall) m_count = m_count + 1;
            if (!m_fault) begin
               if (r_rv) begin
                  m_show_ok = 1'b0;
                  if (r_pc % 4 != 0 || r_pc / 4 >= DEPTH) begin m_fault = 1'b1; m_fpc = r_pc; end
                  else m_issue = r_pc;
               end else if (!r_stall) begin
                  if (m_issue / 4 >= DEPTH) begin
                     m_fault = 1'b1; m_fpc = m_issue; m_show_ok = 1'b0;
                  end else begin
                     m_show = m_issue; m_show_ok = 1'b1; m_issue = m_issue + 4;
                  end
               end
            end
         end
         @(posedge clk); #1;
      end
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      rst4 = 1'b1; stall4 = 1'b0; redirect_valid4 = 1'b0; redirect_pc4 = '0;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_with_stall();
      test_fault_redirect();
      test_reset_mid_stall();
      test_depth_fault();
      test_random(3000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
